mem_page_slave: RTL and testbench
=================================

Name: mem_page_slave

Overview:
- Bus-side memory page that sits directly downstream of the processor's writeMem/readMem bus master, one instance per populated page.
- Decodes the multiplexed address phases: upper byte, unbounded gap, lower byte.
- Claims transactions whose A[15:14] equals its PAGE. Commits write data or returns read data with b_dValid_L.
- Unselected instances track the phases silently so they stay aligned, but never drive the bus.

Parameters:
PAGE, 2'b01, page number matched against A[15:14]
RD_LAT, 2, cycles from lower-address cycle to read-data cycle (legal 1..15)

Ports:
b_Clock  in  1  system clock, all logic on posedge
b_Reset_L  in  1  synchronous active-low reset
b_aValid_L  in  1  low = b_data_in carries an address byte this cycle
b_rW  in  1  1 = read, 0 = write; sampled only with the upper address byte
b_data_in  in  8  bus data/address as seen by the slave
b_dValid_L_in  in  1  master's write-data strobe, low = write data valid
b_data_out  out  8  read data driven toward the bus
b_data_oe  out  1  high = slave drives b_data_out onto the bus
b_dValid_L_out  out  1  low = read data valid this cycle
b_dValid_oe  out  1  high = slave drives b_dValid_L
busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset is synchronous and active-low on b_Clock; there is one clock.
- Reset values: state=IDLE, b_data_out=8'h00, b_data_oe=0, b_dValid_L_out=1, b_dValid_oe=0, busy=0.
- Storage is 16384 x 8, indexed by A[13:0]. Contents are NOT cleared by reset; data written before a reset reads back after it.
- States: IDLE, WAIT_LO, WR_DATA, RD_WAIT, RD_DRIVE.
- IDLE:
  - On b_aValid_L=0, latch hi=b_data_in, rw=b_rW, and sel=(b_data_in[7:6]==PAGE).
  - Go to WAIT_LO.
- WAIT_LO:
  - Stay while b_aValid_L=1, for an unbounded number of cycles; no timeout.
  - First cycle with b_aValid_L=0 latches lo=b_data_in. That address is {hi,lo}.
  - Then: rw=0 goes to WR_DATA; rw=1 and sel goes to RD_WAIT; rw=1 and !sel goes to IDLE.
  - A zero-cycle gap is legal: upper and lower bytes may arrive on consecutive cycles.
- WR_DATA lasts exactly one cycle, the cycle immediately after the lower byte:
  - If sel and b_dValid_L_in=0, write b_data_in to mem[addr[13:0]].
  - If sel and b_dValid_L_in=1, drop the write silently; memory is unchanged.
  - If !sel, ignore the cycle.
  - Always return to IDLE.
- RD_WAIT:
  - Counts so that RD_DRIVE occurs exactly RD_LAT cycles after the lower-address cycle.
  - b_aValid_L=0 during RD_WAIT is a protocol violation and is ignored.
- RD_DRIVE lasts one cycle:
  - b_data_oe=1, b_dValid_oe=1, b_dValid_L_out=0, b_data_out=mem[addr].
  - All three return to their idle values the next cycle. Return to IDLE.
- Drive enables are never high outside RD_DRIVE and never high in an unselected instance.
- A read immediately after a write to the same address returns the new value (no stale read).
- Reset asserted in any state wins that cycle:
  - Next state is IDLE and outputs take their reset values the following cycle.
  - An in-flight write in WR_DATA is not committed if reset is low that cycle.
- Unselected reads produce no response. The master's 20-cycle timeout is the only recovery; the slave is back in IDLE one cycle after the lower byte.

Test Plan:
1. PAGE=01, RD_LAT=2:
   - Write 7F11<-AB, 7F22<-CD, 7E11<-EF, then read each.
   - Each read shows b_dValid_L_out=0 exactly 2 cycles after its lower byte, with data AB/CD/EF.
2. Two instances, PAGE=01 and PAGE=10:
   - Write 7F11<-AB and BF11<-CD, then read both.
   - Reads return AB and CD.
   - The PAGE=10 instance never asserts b_data_oe during page-01 transactions, and vice versa.
3. Unbounded gap:
   - 20 idle cycles between upper and lower byte, write 7F11<-AB, then read with the same 20-cycle gap.
   - Read returns AB; busy stays high throughout the gap.
4. Zero gap:
   - Back-to-back writes 7F11<-43 and 7E11<-78, then read 7F11.
   - Read returns 43; the 7E11 write does not corrupt 7F11.
5. Non-existent page:
   - Write 3F11<-27, then read 3F11.
   - No drive enable is ever asserted on either instance; memory contents are unchanged.
   - Both instances are idle (busy=0) and correctly decode a following read of 7F11=43.
6. Reset mid-transaction:
   - Assert b_Reset_L=0 for 1 cycle during RD_WAIT of a 7F11 read.
   - No b_dValid_L_out pulse follows; outputs are at reset values.
   - A subsequent read of 7F11 returns 43, showing memory persisted across reset.

Source files
------------

// File: rtl/mem_page_if.sv
// Bus bundle between the writeMem/readMem master and a memory page slave.
// Master side drives the multiplexed address/data phases and the write
// strobe; the slave side returns read data, its drive enables and busy.
//   b_aValid_L     : low = b_data_in carries an address byte
//   b_rW           : 1 = read, 0 = write (meaningful with the upper byte)
//   b_data_in      : address/write data as seen by the slave
//   b_dValid_L_in  : master write-data strobe, low = valid
//   b_data_out     : read data toward the bus
//   b_data_oe      : slave drives b_data_out
//   b_dValid_L_out : low = read data valid
//   b_dValid_oe    : slave drives b_dValid_L
//   busy           : slave FSM is not idle
interface mem_page_if;
    logic       b_aValid_L;
    logic       b_rW;
    logic [7:0] b_data_in;
    logic       b_dValid_L_in;
    logic [7:0] b_data_out;
    logic       b_data_oe;
    logic       b_dValid_L_out;
    logic       b_dValid_oe;
    logic       busy;

    modport master (
        output b_aValid_L, b_rW, b_data_in, b_dValid_L_in,
        input  b_data_out, b_data_oe, b_dValid_L_out, b_dValid_oe, busy
    );

    modport slave (
        input  b_aValid_L, b_rW, b_data_in, b_dValid_L_in,
        output b_data_out, b_data_oe, b_dValid_L_out, b_dValid_oe, busy
    );
endinterface

// File: rtl/mem_page_slave.sv
// One 16K x 8 memory page on the multiplexed processor bus.
// Decodes upper address byte, an unbounded gap, then the lower byte.
// Claims the transaction when A[15:14] == PAGE; unselected instances walk
// the same phases so they stay aligned but never drive the bus.
//   b_Clock   : system clock, posedge
//   b_Reset_L : synchronous active-low reset
//   bus       : mem_page_if slave modport (see interface header)
module mem_page_slave #(
    parameter logic [1:0] PAGE   = 2'b01,
    parameter int         RD_LAT = 2      // lower-byte cycle to data cycle, 1..15
) (
    input  logic         b_Clock,
    input  logic         b_Reset_L,
    mem_page_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, WAIT_LO, WR_DATA, RD_WAIT, RD_DRIVE} state_t;

    // RD_WAIT occupies RD_LAT-1 cycles; counter runs down to zero
    localparam logic [3:0] CNT_INIT = 4'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

    state_t     r_state;
    logic [5:0] r_hi;
    logic [7:0] r_lo;
    logic       r_rw;
    logic       r_sel;
    logic [3:0] r_cnt;
    logic [7:0] r_data_out;
    logic       r_data_oe;
    logic       r_dValid_L;
    logic       r_dValid_oe;
    logic       r_busy;

    // Not reset: contents survive b_Reset_L
    logic [7:0] r_mem [16384];

    // With RD_LAT==1 the drive is loaded straight from WAIT_LO, so the low
    // byte comes from the bus rather than r_lo.
    logic [7:0]  w_lo;
    logic [13:0] w_rd_idx;
    logic [7:0]  w_rd_data;

    assign w_lo      = (r_state == WAIT_LO) ? bus.b_data_in : r_lo;
    assign w_rd_idx  = {r_hi, w_lo};
    assign w_rd_data = r_mem[w_rd_idx];

    always_ff @(posedge b_Clock) begin
        if (b_Reset_L && r_state == WR_DATA && r_sel && !bus.b_dValid_L_in)
            r_mem[{r_hi, r_lo}] <= bus.b_data_in;
    end

    always_ff @(posedge b_Clock) begin
        if (!b_Reset_L) begin
            r_state     <= IDLE;
            r_hi        <= '0;
            r_lo        <= '0;
            r_rw        <= 1'b0;
            r_sel       <= 1'b0;
            r_cnt       <= '0;
            r_data_out  <= 8'h00;
            r_data_oe   <= 1'b0;
            r_dValid_L  <= 1'b1;
            r_dValid_oe <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Drive outputs are one-cycle pulses; idle values by default
            r_data_out  <= 8'h00;
            r_data_oe   <= 1'b0;
            r_dValid_L  <= 1'b1;
            r_dValid_oe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!bus.b_aValid_L) begin
                        r_hi    <= bus.b_data_in[5:0];
                        r_rw    <= bus.b_rW;
                        r_sel   <= (bus.b_data_in[7:6] == PAGE);
                        r_state <= WAIT_LO;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!bus.b_aValid_L) begin
                        r_lo <= bus.b_data_in;
                        if (!r_rw) begin
                            r_state <= WR_DATA;
                        end else if (!r_sel) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (RD_LAT == 1) begin
                            r_state     <= RD_DRIVE;
                            r_data_out  <= w_rd_data;
                            r_data_oe   <= 1'b1;
                            r_dValid_L  <= 1'b0;
                            r_dValid_oe <= 1'b1;
                        end else begin
                            r_state <= RD_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WR_DATA: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                RD_WAIT: begin
                    // address strobes here are protocol violations; ignored
                    if (r_cnt == 4'd0) begin
                        r_state     <= RD_DRIVE;
                        r_data_out  <= w_rd_data;
                        r_data_oe   <= 1'b1;
                        r_dValid_L  <= 1'b0;
                        r_dValid_oe <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RD_DRIVE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.b_data_out     = r_data_out;
    assign bus.b_data_oe      = r_data_oe;
    assign bus.b_dValid_L_out = r_dValid_L;
    assign bus.b_dValid_oe    = r_dValid_oe;
    assign bus.busy           = r_busy;
endmodule

// File: tb/tb_mem_page_slave.sv
// Two page slaves (PAGE 01 and 10) on a shared master bus. Reads push the
// expected response into a queue; a negedge monitor pops on every drive.
module tb_mem_page_slave;
    localparam int RD_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       aval, rw, dval;
    logic [7:0] din;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    typedef struct { int cyc; logic [7:0] data; int inst; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] ref_mem[int];
    int         wq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_page_if u_if1 ();
    mem_page_if u_if2 ();

    assign u_if1.b_aValid_L    = aval;
    assign u_if1.b_rW          = rw;
    assign u_if1.b_data_in     = din;
    assign u_if1.b_dValid_L_in = dval;
    assign u_if2.b_aValid_L    = aval;
    assign u_if2.b_rW          = rw;
    assign u_if2.b_data_in     = din;
    assign u_if2.b_dValid_L_in = dval;

    mem_page_slave #(.PAGE(2'b01), .RD_LAT(RD_LAT)) u_p1 (
        .b_Clock(clk), .b_Reset_L(rst_n), .bus(u_if1.slave));
    mem_page_slave #(.PAGE(2'b10), .RD_LAT(RD_LAT)) u_p2 (
        .b_Clock(clk), .b_Reset_L(rst_n), .bus(u_if2.slave));

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic a1, a2, t1, t2;
        exp_t e;
        int   inst;
        logic [7:0] d;
        a1 = u_if1.b_data_oe | u_if1.b_dValid_oe | ~u_if1.b_dValid_L_out;
        a2 = u_if2.b_data_oe | u_if2.b_dValid_oe | ~u_if2.b_dValid_L_out;
        t1 = u_if1.b_data_oe & u_if1.b_dValid_oe & ~u_if1.b_dValid_L_out;
        t2 = u_if2.b_data_oe & u_if2.b_dValid_oe & ~u_if2.b_dValid_L_out;
        if (a1 || a2) begin
            tests++;
            inst = a1 ? 1 : 2;
            d    = a1 ? u_if1.b_data_out : u_if2.b_data_out;
            if (a1 && a2) begin
                fails++;
                $display("FAIL both_drive cyc=%0d both instances drive", cyc);
            end else if ((a1 && !t1) || (a2 && !t2)) begin
                fails++;
                $display("FAIL drive_triple cyc=%0d inst=%0d oe/dv_oe/dv_L not all active", cyc, inst);
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_resp cyc=%0d inst=%0d data=%02h, none expected", cyc, inst, d);
            end else begin
                e = exp_q.pop_front();
                if (e.inst != inst || e.cyc != cyc || e.data != d) begin
                    fails++;
                    $display("FAIL read_resp got inst=%0d cyc=%0d data=%02h, want inst=%0d cyc=%0d data=%02h",
                             inst, cyc, d, e.inst, e.cyc, e.data);
                end
            end
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_resp want cyc=%0d inst=%0d data=%02h, no drive", exp_q[0].cyc, exp_q[0].inst, exp_q[0].data);
            void'(exp_q.pop_front());
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy1"}, {7'd0, u_if1.busy}, 8'h00);
        chk({tag, "_busy2"}, {7'd0, u_if2.busy}, 8'h00);
        chk({tag, "_out1"}, {4'd0, u_if1.b_data_oe, u_if1.b_dValid_oe, u_if1.b_dValid_L_out, 1'b0}, 8'h02);
        chk({tag, "_out2"}, {4'd0, u_if2.b_data_oe, u_if2.b_dValid_oe, u_if2.b_dValid_L_out, 1'b0}, 8'h02);
        chk({tag, "_dout1"}, u_if1.b_data_out, 8'h00);
        chk({tag, "_dout2"}, u_if2.b_data_out, 8'h00);
    endtask

    function automatic int page_of(input logic [15:0] a);
        return int'(a[15:14]);
    endfunction

    task automatic addr_phase(input logic [15:0] a, input logic r, input int gap);
        aval = 1'b0; rw = r; din = a[15:8];
        step();
        aval = 1'b1; rw = ~r; din = 8'($urandom);
        for (int g = 0; g < gap; g++) begin
            chk("gap_busy", {6'd0, u_if1.busy, u_if2.busy}, 8'h03);
            step();
        end
        aval = 1'b0; din = a[7:0]; rw = 1'($urandom);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int gap, input logic strobe);
        addr_phase(a, 1'b0, gap);
        step();
        aval = 1'b1; dval = ~strobe; din = d;
        step();
        dval = 1'b1; din = 8'($urandom);
        if (strobe && (page_of(a) == 1 || page_of(a) == 2)) begin
            ref_mem[int'(a)] = d;
            wq.push_back(int'(a));
        end
    endtask

    task automatic rd(input logic [15:0] a, input int gap);
        exp_t e;
        addr_phase(a, 1'b1, gap);
        if (page_of(a) == 1 || page_of(a) == 2) begin
            e.cyc = cyc + RD_LAT; e.data = ref_mem[int'(a)]; e.inst = page_of(a);
            exp_q.push_back(e);
        end
        step();
        aval = 1'b1;
        repeat (RD_LAT + 1) step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d run did not finish", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; aval = 1'b1; rw = 1'b0; dval = 1'b1; din = 8'h00;
        step(); step(); step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // 1: basic writes/reads on page 01
        wr(16'h7F11, 8'hAB, 1, 1'b1);
        wr(16'h7F22, 8'hCD, 2, 1'b1);
        wr(16'h7E11, 8'hEF, 0, 1'b1);
        rd(16'h7F11, 1); rd(16'h7F22, 3); rd(16'h7E11, 0);

        // 2: two pages, same low index
        wr(16'hBF11, 8'hCD, 1, 1'b1);
        rd(16'h7F11, 1); rd(16'hBF11, 1);

        // 3: long gap, busy checked every gap cycle
        wr(16'h7F11, 8'hAB, 20, 1'b1);
        rd(16'h7F11, 20);

        // 4: zero gap, back-to-back writes
        wr(16'h7F11, 8'h43, 0, 1'b1);
        wr(16'h7E11, 8'h78, 0, 1'b1);
        rd(16'h7F11, 0);

        // 5: non-existent page aliasing the same low index
        wr(16'h3F11, 8'h27, 1, 1'b1);
        rd(16'h3F11, 1);
        chk_idle_outputs("nopage");
        rd(16'h7F11, 1); rd(16'hBF11, 2);

        // 6: reset during RD_WAIT
        addr_phase(16'h7F11, 1'b1, 1);
        step();
        aval = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle_outputs("rst_rd");
        repeat (3) step();
        rd(16'h7F11, 1);

        // reset during WR_DATA drops the write
        wr(16'h7F33, 8'h11, 0, 1'b1);
        addr_phase(16'h7F33, 1'b0, 0);
        step();
        aval = 1'b1; dval = 1'b0; din = 8'h55; rst_n = 1'b0;
        step();
        dval = 1'b1; rst_n = 1'b1;
        chk_idle_outputs("rst_wr");
        rd(16'h7F33, 0);

        // dropped write (strobe high) leaves memory unchanged
        wr(16'h7F33, 8'h99, 0, 1'b0);
        rd(16'h7F33, 0);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            int gap;
            logic [15:0] a;
            gap = $urandom_range(0, 4);
            if (wq.size() == 0 || $urandom_range(0, 1) == 0) begin
                a = 16'($urandom);
                wr(a, 8'($urandom), gap, ($urandom_range(0, 9) != 0));
            end else if ($urandom_range(0, 4) == 0) begin
                a = 16'($urandom);
                a[15] = a[14];               // page 00 or 11: no responder
                rd(a, gap);
            end else begin
                rd(16'(wq[$urandom_range(0, wq.size() - 1)]), gap);
            end
        end

        repeat (5) step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain %0d responses outstanding, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
